// File: rtl/registered_priority_arbiter_if.sv
// -----------------------------------------------------------------------------
// registered_priority_arbiter_if
//
// Purpose : Bundles the request/grant handshake between a set of requesters
//           and the registered priority arbiter.
//
// Signals : req          [N-1:0]     request lines, bit i = requester i (level)
//           mode                     0 = fixed priority, 1 = round-robin
//           ack                      consumer ends the current grant
//           grant_idx    [IDXW-1:0]  encoded index of the granted requester
//           grant_onehot [N-1:0]     one-hot grant vector (zero when idle)
//           valid                    a grant is active
//           busy_cycles  [15:0]      cycles the current grant has been held
//
// Modports: master - requester/consumer side (drives req, mode, ack)
//           slave  - arbiter side (drives the grant outputs)
// -----------------------------------------------------------------------------
interface registered_priority_arbiter_if #(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
);

  logic [N-1:0]    req;
  logic            mode;
  logic            ack;
  logic [IDXW-1:0] grant_idx;
  logic [N-1:0]    grant_onehot;
  logic            valid;
  logic [15:0]     busy_cycles;

  modport master (
    output req,
    output mode,
    output ack,
    input  grant_idx,
    input  grant_onehot,
    input  valid,
    input  busy_cycles
  );

  modport slave (
    input  req,
    input  mode,
    input  ack,
    output grant_idx,
    output grant_onehot,
    output valid,
    output busy_cycles
  );

endinterface : registered_priority_arbiter_if

// File: rtl/registered_priority_arbiter.sv
// -----------------------------------------------------------------------------
// registered_priority_arbiter
//
// Purpose : N-request arbiter with registered outputs. A winner is chosen
//           either by fixed priority (highest set index wins) or round-robin
//           (first set bit above the last winner, wrapping). Once granted, the
//           grant is held stable until the consumer acknowledges it; an ack
//           with requests pending re-arbitrates on the same edge so grants can
//           run back-to-back with valid held high.
//
// Ports   : i_clk   system clock, rising edge
//           i_rst   synchronous active-high reset, overrides everything
//           io_arb  slave modport of registered_priority_arbiter_if
//                   (req, mode, ack in; grant_idx, grant_onehot, valid,
//                    busy_cycles out)
//
// Parameters: N    number of request lines (2..32)
//             IDXW width of the encoded grant index
// -----------------------------------------------------------------------------
module registered_priority_arbiter #(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  registered_priority_arbiter_if.slave    io_arb
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [IDXW:0]   N_EXT      = (IDXW+1)'(N);
  localparam logic [IDXW-1:0] PTR_RESET  = IDXW'(N - 1);
  localparam logic [15:0]     BUSY_MAX   = 16'hFFFF;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          r_state;
  state_e          w_state_next;

  logic [IDXW-1:0] r_grant_idx;
  logic [N-1:0]    r_grant_onehot;
  logic            r_valid;
  logic [15:0]     r_busy_cycles;
  logic [IDXW-1:0] r_rr_ptr;

  // ---------------------------------------------------------------------------
  // Arbitration datapath
  // ---------------------------------------------------------------------------
  logic            w_any_req;
  logic [IDXW-1:0] w_fixed_idx;
  logic [IDXW:0]   w_rr_shamt;
  logic [N-1:0]    w_req_rot;
  logic [IDXW-1:0] w_rr_off;
  logic [IDXW:0]   w_rr_sum;
  logic [IDXW-1:0] w_rr_idx;
  logic [IDXW-1:0] w_winner_idx;
  logic [N-1:0]    w_winner_onehot;

  // FSM decode
  logic            w_load;     // capture a new winner this edge
  logic            w_release;  // grant ends with nobody waiting
  logic            w_hold;     // grant continues, count the cycle

  assign w_any_req = |io_arb.req;

  // Fixed priority: ascending scan, so the highest set index overwrites the
  // lower ones and wins.
  // NOTE: every variable written in a combinational block gets a default at
  // the top; a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_fixed_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (io_arb.req[i]) w_fixed_idx = IDXW'(i);
    end
  end

  // Round-robin: rotate the request vector so bit 0 is the requester just
  // above the pointer, find the lowest set bit there, then map the offset
  // back to an absolute index modulo N. Doubling the vector makes the
  // rotation wrap without a variable bit select, and works for any N.
  assign w_rr_shamt = {1'b0, r_rr_ptr} + (IDXW+1)'(1);
  assign w_req_rot  = N'({io_arb.req, io_arb.req} >> w_rr_shamt);

  always_comb begin
    w_rr_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_req_rot[i]) w_rr_off = IDXW'(i);
    end
  end

  // ptr + 1 + off is at most 2N-1, so a single conditional subtract wraps it.
  always_comb begin
    w_rr_sum = w_rr_shamt + {1'b0, w_rr_off};
    if (w_rr_sum >= N_EXT) w_rr_sum = w_rr_sum - N_EXT;
  end

  assign w_rr_idx = w_rr_sum[IDXW-1:0];

  // mode only matters on the edge where a winner is loaded, so the held
  // grant is unaffected by mode changes mid-grant.
  assign w_winner_idx    = io_arb.mode ? w_rr_idx : w_fixed_idx;
  assign w_winner_onehot = {{(N-1){1'b0}}, 1'b1} << w_winner_idx;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_release    = 1'b0;
    w_hold       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // ack is meaningless without a grant and is ignored here.
        if (w_any_req) begin
          w_load       = 1'b1;
          w_state_next = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (io_arb.ack) begin
          if (w_any_req) begin
            // Back-to-back: the just-acked requester competes again too.
            w_load       = 1'b1;
            w_state_next = ST_GRANT;
          end else begin
            w_release    = 1'b1;
            w_state_next = ST_IDLE;
          end
        end else begin
          w_hold = 1'b1;
        end
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Grant registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant_idx    <= '0;
      r_grant_onehot <= '0;
      r_valid        <= 1'b0;
      r_busy_cycles  <= '0;
      r_rr_ptr       <= PTR_RESET;
    end else if (w_load) begin
      r_grant_idx    <= w_winner_idx;
      r_grant_onehot <= w_winner_onehot;
      r_valid        <= 1'b1;
      r_busy_cycles  <= '0;
      // Pointer follows every grant, fixed mode included, so a later switch
      // to round-robin continues from the most recent winner.
      r_rr_ptr       <= w_winner_idx;
    end else if (w_release) begin
      // busy_cycles keeps its final count while idle.
      r_grant_idx    <= '0;
      r_grant_onehot <= '0;
      r_valid        <= 1'b0;
    end else if (w_hold) begin
      if (r_busy_cycles != BUSY_MAX) r_busy_cycles <= r_busy_cycles + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign io_arb.grant_idx    = r_grant_idx;
  assign io_arb.grant_onehot = r_grant_onehot;
  assign io_arb.valid        = r_valid;
  assign io_arb.busy_cycles  = r_busy_cycles;

endmodule : registered_priority_arbiter

// File: tb/tb_registered_priority_arbiter.sv
// -----------------------------------------------------------------------------
// tb_registered_priority_arbiter
//
// Self-checking bench for registered_priority_arbiter with N=4. A behavioural
// model tracks grant, pointer and busy count from the arbitration rules; a
// compare process checks the DUT against it every cycle, and a directed
// sequence pins the model with literal expectations before a random phase.
// -----------------------------------------------------------------------------
module tb_registered_priority_arbiter;

  localparam int N    = 4;
  localparam int IDXW = $clog2(N);

  logic clk = 1'b0;
  logic rst;

  registered_priority_arbiter_if #(.N(N), .IDXW(IDXW)) bus ();

  registered_priority_arbiter #(.N(N), .IDXW(IDXW)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_arb (bus)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit m_valid = 1'b0;
  int m_idx   = 0;
  int m_busy  = 0;
  int m_ptr   = N - 1;

  // Winner by rule: fixed = highest set index; RR = first set index strictly
  // after ptr, wrapping. Returns -1 for no request.
  function automatic int pick(input logic [N-1:0] r, input logic md, input int p);
    if (!md) begin
      for (int i = N - 1; i >= 0; i--)
        if (((r >> i) & 1) != 0) return i;
    end else begin
      for (int k = 1; k <= N; k++)
        if (((r >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic s_rst, input logic [N-1:0] s_req,
                            input logic s_mode, input logic s_ack);
    int w;
    if (s_rst) begin
      m_valid = 1'b0; m_idx = 0; m_busy = 0; m_ptr = N - 1;
    end else if (!m_valid || s_ack) begin
      w = pick(s_req, s_mode, m_ptr);
      if (w >= 0) begin
        m_valid = 1'b1; m_idx = w; m_busy = 0; m_ptr = w;
      end else begin
        m_valid = 1'b0;
      end
    end else begin
      m_busy = (m_busy < 65535) ? m_busy + 1 : 65535;
    end
  endtask

  // One clock: inputs already applied are what the edge samples.
  task automatic tick();
    logic         s_rst  = rst;
    logic [N-1:0] s_req  = bus.req;
    logic         s_mode = bus.mode;
    logic         s_ack  = bus.ack;
    @(posedge clk);
    model_step(s_rst, s_req, s_mode, s_ack);
    #1;
    cmp_en = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model (falling edge, away from updates)
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("valid", 32'(bus.valid), 32'(m_valid));
      if (m_valid) check("grant_idx", 32'(bus.grant_idx), 32'(m_idx));
      check("grant_onehot", 32'(bus.grant_onehot),
            m_valid ? (32'd1 << m_idx) : 32'd0);
      check("busy_cycles", 32'(bus.busy_cycles), 32'(m_busy));
    end
  end

  // ---------------------------------------------------------------------------
  // Literal expectations
  // ---------------------------------------------------------------------------
  task automatic expect_grant(input string name, input int idx, input int busy);
    check({name, ".valid"}, 32'(bus.valid), 32'd1);
    check({name, ".idx"},   32'(bus.grant_idx), 32'(idx));
    check({name, ".busy"},  32'(bus.busy_cycles), 32'(busy));
  endtask

  task automatic expect_idle(input string name, input int busy);
    check({name, ".valid"},  32'(bus.valid), 32'd0);
    check({name, ".onehot"}, 32'(bus.grant_onehot), 32'd0);
    check({name, ".busy"},   32'(bus.busy_cycles), 32'(busy));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; bus.req = '0; bus.mode = 1'b0; bus.ack = 1'b0;

    // Reset and idle
    tick(); tick();
    expect_idle("reset", 0);
    check("reset.idx", 32'(bus.grant_idx), 32'd0);
    rst = 1'b0;
    tick();
    expect_idle("idle_noreq", 0);

    // Fixed priority
    bus.req = 4'b0001; tick();
    expect_grant("fixed_0001", 0, 0);
    bus.req = 4'b0000; tick();
    expect_grant("fixed_hold_dropped", 0, 1);
    bus.req = 4'b1011; bus.ack = 1'b1; tick();
    expect_grant("fixed_1011", 3, 0);
    bus.ack = 1'b0; tick();
    expect_grant("fixed_1011_hold", 3, 1);
    bus.req = 4'b0110; bus.ack = 1'b1; tick();
    expect_grant("fixed_0110", 2, 0);
    bus.req = 4'b0000; tick();
    expect_idle("fixed_release", 0);
    bus.ack = 1'b0;

    // Round-robin back-to-back from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    bus.mode = 1'b1; bus.req = 4'b1111; tick();
    expect_grant("rr_first", 0, 0);
    bus.ack = 1'b1;
    tick(); expect_grant("rr_seq1", 1, 0);
    tick(); expect_grant("rr_seq2", 2, 0);
    tick(); expect_grant("rr_seq3", 3, 0);
    tick(); expect_grant("rr_wrap", 0, 0);

    // Grant hold while requests change
    bus.req = 4'b0100; tick();
    expect_grant("hold_load", 2, 0);
    bus.ack = 1'b0; bus.req = 4'b1000;
    tick(); expect_grant("hold_b1", 2, 1);
    tick(); expect_grant("hold_b2", 2, 2);
    tick(); expect_grant("hold_b3", 2, 3);
    bus.ack = 1'b1; tick();
    expect_grant("hold_next", 3, 0);
    bus.ack = 1'b0; tick();
    expect_grant("hold_next_b1", 3, 1);

    // Release to idle, busy holds, ack ignored in idle, restart
    bus.ack = 1'b1; bus.req = 4'b0000; tick();
    expect_idle("release", 1);
    tick();
    expect_idle("ack_in_idle", 1);
    bus.ack = 1'b0; bus.req = 4'b0100; tick();
    expect_grant("restart", 2, 0);

    // Reset mid-grant
    rst = 1'b1; tick();
    expect_idle("rst_mid_grant", 0);
    rst = 1'b0; bus.req = 4'b0000; tick();

    // RR wrap with ptr=1, then mode switch
    bus.mode = 1'b1; bus.req = 4'b0010; tick();
    expect_grant("rr_ptr1", 1, 0);
    bus.ack = 1'b1; bus.req = 4'b0011; tick();
    expect_grant("rr_wrap_0011", 0, 0);
    bus.mode = 1'b0; tick();
    expect_grant("fixed_0011", 1, 0);

    // Saturation of busy_cycles, with a mode toggle mid-grant
    bus.ack = 1'b0;
    bus.mode = 1'b1;
    repeat (65540) tick();
    expect_grant("busy_sat", 1, 65535);
    bus.ack = 1'b1; bus.req = 4'b0000; tick();
    expect_idle("busy_sat_idle", 65535);
    bus.ack = 1'b0;

    // Random phase against the model
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      bus.req  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
      bus.mode = 1'($urandom_range(0, 1));
      bus.ack  = ($urandom_range(0, 2) == 0);
      tick();
    end

    rst = 1'b0; bus.req = '0; bus.ack = 1'b0;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_registered_priority_arbiter

// File: doc/registered_priority_arbiter.md
Name: registered_priority_arbiter

Overview:
- Parametrised N-request priority encoder/arbiter; successor to the 4-to-2 gate-level priority encoder.
- Registered outputs, selectable fixed-priority or round-robin mode, grant hold with request/acknowledge handshake.
- Sits between multiple requesters (e.g. interrupt or bus sources) and a single shared consumer.

Parameters:
- N, 8, number of request lines (2..32).
- IDXW, $clog2(N), width of encoded grant index.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  N  request lines; bit i = requester i; level-sensitive.
- mode  input  1  0 = fixed priority (highest index wins, as in 4-to-2 encoder: D3 over D0); 1 = round-robin.
- ack  input  1  consumer acknowledges current grant; ends the grant.
- grant_idx  output  IDXW  encoded index of granted requester.
- grant_onehot  output  N  one-hot grant vector.
- valid  output  1  a grant is active (V of the encoder, registered).
- busy_cycles  output  16  count of cycles the current grant has been held; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=1 at clk edge): grant_idx=0, grant_onehot=0, valid=0, busy_cycles=0, rr pointer=N-1 (so first RR grant searches from index 0 upward... see below), state=IDLE.
- Clock and reset: single clock domain; rst has priority over every other input and may assert mid-grant: the grant is dropped next edge, with no ack required.
- FSM states:
  - IDLE: valid=0. If |req, select winner, load grant regs and go to GRANT. Outputs are visible 1 cycle after req is sampled (latency 1).
  - GRANT: valid=1, grant held stable regardless of req changes, including the granted bit deasserting. busy_cycles increments each cycle in GRANT.
  - On ack=1 in GRANT: release.
    - If |req in the same cycle: re-arbitrate immediately and load the new grant next edge (back-to-back; valid stays 1, busy_cycles reset to 0).
    - Else: go to IDLE with valid=0.
  - The req sampled for re-arbitration is the current-cycle req, including the just-acked requester.
- Fixed mode: winner = highest set index of req. Example: req=4'b1011 gives 3.
- Round-robin mode:
  - Winner = first set bit searching upward from (ptr+1) mod N, wrapping.
  - ptr updates to the winner index on each grant.
  - ptr is updated in fixed mode too, so a switch to RR continues fairly.
- mode is sampled only at arbitration instants; a change during GRANT has no effect on the held grant.
- ack in IDLE is ignored.
- grant_onehot == (1 << grant_idx) when valid=1; all zeros when valid=0.
- busy_cycles = 0 on the cycle the grant loads, +1 per subsequent GRANT cycle, saturating at 16'hFFFF. It holds its last value in IDLE until the next grant loads.
- req all-zero: no grant, valid=0. This is the encoder's V=0 case.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then req=0 → valid=0, grant_idx=0, grant_onehot=0 throughout.
- Fixed priority (N=4 bench instance, mode=0): req=4'b0001 → idx 0; 4'b1011 → idx 3; 4'b0110 → idx 2. Each result appears one cycle after req, held until ack.
- Round-robin (N=4, mode=1): req=4'b1111 held, ack pulsed each grant → grant sequence 0,1,2,3,0 with valid continuously 1 (back-to-back).
- Grant hold: grant idx 2, then drop req[2] and raise req[3] without ack → grant stays 2 and busy_cycles counts 0,1,2,3. After ack, grant moves to 3 next cycle.
- Release to idle: ack with req=0 → valid=0 next cycle and busy_cycles holds its last value. A later req=4'b0100 → idx 2 and busy_cycles restarts at 0.
- Reset mid-grant and mode switch: rst during GRANT → valid=0 next edge. In RR with ptr=1, req=4'b0011 → idx 0 after wrap; switching to mode=0 → idx 1.
